// File: rtl/lab3_cache_cache_arbiter.sv
// rtl/lab3_cache_cache_arbiter.sv - two-requester (imem/dmem) arbiter in front of one cache port
//
// Purpose: shares a single cache request/response port between the instruction
// and data memory streams. Grants are made combinationally, and round-robin is
// used when both streams are valid. An in-order ID FIFO records which side owns
// each in-flight request, so that responses return to the right side. A flush
// request first drains in-flight traffic and then issues a one-cycle flush
// command to the cache.
//
// Build option: define LAB3_CACHE_ARB_FIXED_PRIO_EN for fixed priority. With it,
// dmem always wins a tie and no priority pointer is built.
//
// Ports:
//   clk, reset              clock; asynchronous active-low reset
//   imemreq_*/dmemreq_*     request streams from the processor (val/rdy/msg)
//   imemresp_*/dmemresp_*   response streams to the processor (val/rdy/msg)
//   cache_req_*             request stream to the cache
//   cache_resp_*            response stream from the cache
//   flush, flush_done       flush request pulse in, completion pulse out
//   cache_flush(_done)      flush command to the cache, completion pulse back
//
// Message layouts (passed through untouched):
//   request  {type[2:0], opaque[7:0], addr[31:0], len[1:0], data[31:0]} = 77 bits
//   response {type[2:0], opaque[7:0], test[1:0],  len[1:0], data[31:0]} = 47 bits

module lab3_cache_cache_arbiter #(
    parameter int NUM_OUTSTANDING = 4,
    parameter int REQ_W           = 77,
    parameter int RESP_W          = 47
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              imemreq_val,
    output logic              imemreq_rdy,
    input  logic [REQ_W-1:0]  imemreq_msg,
    output logic              imemresp_val,
    input  logic              imemresp_rdy,
    output logic [RESP_W-1:0] imemresp_msg,

    input  logic              dmemreq_val,
    output logic              dmemreq_rdy,
    input  logic [REQ_W-1:0]  dmemreq_msg,
    output logic              dmemresp_val,
    input  logic              dmemresp_rdy,
    output logic [RESP_W-1:0] dmemresp_msg,

    output logic              cache_req_val,
    input  logic              cache_req_rdy,
    output logic [REQ_W-1:0]  cache_req_msg,
    input  logic              cache_resp_val,
    output logic              cache_resp_rdy,
    input  logic [RESP_W-1:0] cache_resp_msg,

    input  logic              flush,
    output logic              flush_done,
    output logic              cache_flush,
    input  logic              cache_flush_done
);

    localparam int PW = $clog2(NUM_OUTSTANDING);

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_FLUSH, S_WAIT} state_t;

    state_t                     state_q, state_d;
    logic [NUM_OUTSTANDING-1:0] id_q, id_d;         // 0 = imem, 1 = dmem
    logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
    logic [PW:0]                count_q, count_d;
`ifndef LAB3_CACHE_ARB_FIXED_PRIO_EN
    logic                       prio_q, prio_d;     // 1 = dmem preferred on a tie
`endif

    logic fifo_full, fifo_empty, grant_en, sel, push, pop, head, resp_en;

    // Request path: select, handshake and FIFO push.
    always_comb begin
        fifo_full  = (count_q == (PW+1)'(NUM_OUTSTANDING));
        fifo_empty = (count_q == '0);
        // While reset is low every handshake output must stay low.
        grant_en   = reset && (state_q == S_RUN) && !fifo_full;

        if (imemreq_val && dmemreq_val) begin
`ifdef LAB3_CACHE_ARB_FIXED_PRIO_EN
            sel = 1'b1;
`else
            sel = prio_q;
`endif
        end else begin
            sel = dmemreq_val;
        end

        cache_req_val = grant_en && (imemreq_val || dmemreq_val);
        cache_req_msg = sel ? dmemreq_msg : imemreq_msg;
        imemreq_rdy   = grant_en && !sel && cache_req_rdy;
        dmemreq_rdy   = grant_en &&  sel && cache_req_rdy;
        push          = cache_req_val && cache_req_rdy;

        // Response path: the FIFO head owns the response. A stalled head blocks
        // everything behind it, which keeps responses in order.
        head           = id_q[rd_ptr_q];
        resp_en        = reset && !fifo_empty;
        imemresp_val   = resp_en && !head && cache_resp_val;
        dmemresp_val   = resp_en &&  head && cache_resp_val;
        cache_resp_rdy = resp_en && (head ? dmemresp_rdy : imemresp_rdy);
        imemresp_msg   = cache_resp_msg;
        dmemresp_msg   = cache_resp_msg;
        pop            = cache_resp_val && cache_resp_rdy;

        id_d = id_q;
        if (push) begin
            id_d[wr_ptr_q] = sel;
        end
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + (PW+1)'(push) - (PW+1)'(pop);
`ifndef LAB3_CACHE_ARB_FIXED_PRIO_EN
        prio_d   = push ? ~sel : prio_q;
`endif
    end

    // Flush sequencing.
    always_comb begin
        state_d     = state_q;
        cache_flush = 1'b0;
        flush_done  = 1'b0;
        case (state_q)
            S_RUN:   if (flush) state_d = S_DRAIN;
            // The next-cycle count is used here, so that FLUSH follows the last
            // response by exactly one cycle.
            S_DRAIN: if (count_d == '0) state_d = S_FLUSH;
            S_FLUSH: begin
                cache_flush = 1'b1;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                if (cache_flush_done) begin
                    flush_done = 1'b1;
                    state_d    = S_RUN;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_RUN;
            id_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
`ifndef LAB3_CACHE_ARB_FIXED_PRIO_EN
            prio_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
`ifndef LAB3_CACHE_ARB_FIXED_PRIO_EN
            prio_q   <= prio_d;
`endif
        end
    end

endmodule

// File: tb/tb_lab3_cache_cache_arbiter.sv
// tb/tb_lab3_cache_cache_arbiter.sv - self-checking bench for lab3_cache_cache_arbiter

module tb_lab3_cache_cache_arbiter;

    localparam int NO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        imemreq_val, imemreq_rdy, imemresp_val, imemresp_rdy;
    logic        dmemreq_val, dmemreq_rdy, dmemresp_val, dmemresp_rdy;
    logic [76:0] imemreq_msg, dmemreq_msg, cache_req_msg;
    logic [46:0] imemresp_msg, dmemresp_msg, cache_resp_msg;
    logic        cache_req_val, cache_req_rdy, cache_resp_val, cache_resp_rdy;
    logic        flush, flush_done, cache_flush, cache_flush_done;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the in-order queue of owners (0 imem, 1 dmem) of
    // outstanding requests, and the preferred side for the next tie.
    bit q[$];
    bit pref = 1'b0;

    lab3_cache_cache_arbiter #(.NUM_OUTSTANDING(NO)) dut (
        .clk(clk), .reset(reset),
        .imemreq_val(imemreq_val), .imemreq_rdy(imemreq_rdy), .imemreq_msg(imemreq_msg),
        .imemresp_val(imemresp_val), .imemresp_rdy(imemresp_rdy), .imemresp_msg(imemresp_msg),
        .dmemreq_val(dmemreq_val), .dmemreq_rdy(dmemreq_rdy), .dmemreq_msg(dmemreq_msg),
        .dmemresp_val(dmemresp_val), .dmemresp_rdy(dmemresp_rdy), .dmemresp_msg(dmemresp_msg),
        .cache_req_val(cache_req_val), .cache_req_rdy(cache_req_rdy), .cache_req_msg(cache_req_msg),
        .cache_resp_val(cache_resp_val), .cache_resp_rdy(cache_resp_rdy), .cache_resp_msg(cache_resp_msg),
        .flush(flush), .flush_done(flush_done), .cache_flush(cache_flush),
        .cache_flush_done(cache_flush_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [76:0] rnd_req();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[76:0];
    endfunction

    function automatic logic [46:0] rnd_resp();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[46:0];
    endfunction

    task automatic set_in(input bit iv, input bit dv, input bit crdy,
                          input bit rv, input bit irr, input bit drr);
        imemreq_val = iv;  dmemreq_val = dv;  cache_req_rdy = crdy;
        cache_resp_val = rv; imemresp_rdy = irr; dmemresp_rdy = drr;
        imemreq_msg = rnd_req(); dmemreq_msg = rnd_req(); cache_resp_msg = rnd_resp();
    endtask

    // Called at posedge+1 with inputs already applied. grant_ok says whether the
    // arbiter is expected to be taking requests (normal running, not flushing).
    task automatic run_cycle(input bit grant_ok, input bit exp_cf, input bit exp_fd);
        bit sel, ev, push, pop, head, exp_rdy;
        @(negedge clk);
        if (imemreq_val && dmemreq_val) begin
`ifdef LAB3_CACHE_ARB_FIXED_PRIO_EN
            sel = 1'b1;
`else
            sel = pref;
`endif
        end else begin
            sel = dmemreq_val;
        end
        ev   = grant_ok && (q.size() < NO) && (imemreq_val || dmemreq_val);
        push = ev && cache_req_rdy;
        chk("cache_req_val", cache_req_val, ev);
        if (ev) chk("cache_req_msg", cache_req_msg, sel ? dmemreq_msg : imemreq_msg);
        if (imemreq_val) chk("imemreq_rdy", imemreq_rdy, ev && !sel && cache_req_rdy);
        if (dmemreq_val) chk("dmemreq_rdy", dmemreq_rdy, ev && sel && cache_req_rdy);
        if (q.size() == 0) begin
            pop = 1'b0;
            chk("cache_resp_rdy_empty", cache_resp_rdy, 1'b0);
            chk("imemresp_val_empty", imemresp_val, 1'b0);
            chk("dmemresp_val_empty", dmemresp_val, 1'b0);
        end else begin
            head    = q[0];
            exp_rdy = head ? dmemresp_rdy : imemresp_rdy;
            pop     = cache_resp_val && exp_rdy;
            chk("cache_resp_rdy", cache_resp_rdy, exp_rdy);
            chk("imemresp_val", imemresp_val, cache_resp_val && !head);
            chk("dmemresp_val", dmemresp_val, cache_resp_val && head);
            chk("resp_msg", head ? dmemresp_msg : imemresp_msg, cache_resp_msg);
        end
        chk("cache_flush", cache_flush, exp_cf);
        chk("flush_done", flush_done, exp_fd);
        if (pop) void'(q.pop_front());
        if (push) begin
            q.push_back(sel);
            pref = !sel;
        end
        @(posedge clk); #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cache_req_val"}, cache_req_val, 1'b0);
        chk({tag, "_imemreq_rdy"}, imemreq_rdy, 1'b0);
        chk({tag, "_dmemreq_rdy"}, dmemreq_rdy, 1'b0);
        chk({tag, "_imemresp_val"}, imemresp_val, 1'b0);
        chk({tag, "_dmemresp_val"}, dmemresp_val, 1'b0);
        chk({tag, "_cache_resp_rdy"}, cache_resp_rdy, 1'b0);
        chk({tag, "_cache_flush"}, cache_flush, 1'b0);
        chk({tag, "_flush_done"}, flush_done, 1'b0);
    endtask

    initial begin
        // Reset with every input asserted: all handshake outputs must stay low.
        reset = 1'b0; flush = 1'b0; cache_flush_done = 1'b1;
        set_in(1, 1, 1, 1, 1, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;
        reset = 1'b1; cache_flush_done = 1'b0;

        // Single imem read at 0x1000, then its response with opaque 0x05.
        set_in(1, 0, 1, 0, 1, 1);
        imemreq_msg = {3'd0, 8'h00, 32'h0000_1000, 2'd0, 32'd0};
        run_cycle(1, 0, 0);
        set_in(0, 0, 1, 1, 1, 1);
        cache_resp_msg = {3'd0, 8'h05, 2'd0, 2'd0, 32'd0};
        run_cycle(1, 0, 0);
        chk("single_drained", q.size(), 0);

        // Both sides valid, cache ready and responses always accepted.
        for (int i = 0; i < 8; i++) begin
            set_in(1, 1, 1, 1, 1, 1);
            run_cycle(1, 0, 0);
        end

        // Drain, then fill the FIFO without responses; the fifth request must stall.
        for (int i = 0; i < 5; i++) begin
            set_in(0, 0, 1, 1, 1, 1);
            run_cycle(1, 0, 0);
        end
        for (int i = 0; i < 5; i++) begin
            set_in(1, 1, 1, 0, 1, 1);
            run_cycle(1, 0, 0);
        end
        chk("full_depth", q.size(), NO);
        set_in(1, 1, 1, 1, 1, 1);   // a pop while full does not admit a push
        run_cycle(1, 0, 0);
        set_in(1, 1, 1, 0, 1, 1);   // freed slot is granted in the next cycle
        run_cycle(1, 0, 0);

        // Randomized traffic with random back-pressure on every port.
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
            run_cycle(1, 0, 0);
        end

        // Drain, then build two outstanding requests.
        for (int i = 0; i < 8; i++) begin
            set_in(0, 0, 1, 1, 1, 1);
            run_cycle(1, 0, 0);
        end
        set_in(1, 0, 1, 0, 1, 1); run_cycle(1, 0, 0);
        set_in(0, 1, 1, 0, 1, 1); run_cycle(1, 0, 0);
        chk("pre_flush_depth", q.size(), 2);

        // A flush in the same cycle as a grant: the grant completes, then draining starts.
        set_in(1, 0, 1, 0, 1, 1); flush = 1'b1;
        run_cycle(1, 0, 0);
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_in(1, 1, 1, 1, 1, 1);
            run_cycle(0, 0, 0);
        end
        set_in(1, 1, 1, 1, 1, 1); run_cycle(0, 1, 0);     // one cycle after the last response
        set_in(1, 1, 1, 0, 1, 1); flush = 1'b1;           // a flush while waiting is ignored
        run_cycle(0, 0, 0);
        flush = 1'b0; cache_flush_done = 1'b1;
        set_in(0, 0, 1, 0, 1, 1); run_cycle(0, 0, 1);
        cache_flush_done = 1'b0;
        set_in(1, 1, 1, 0, 1, 1); run_cycle(1, 0, 0);     // running again
        set_in(0, 0, 1, 1, 1, 1); run_cycle(1, 0, 0);

        // Flush with an empty FIFO: cache_flush two cycles after the request.
        set_in(0, 0, 1, 0, 1, 1); flush = 1'b1;
        run_cycle(1, 0, 0);
        flush = 1'b0;
        run_cycle(0, 0, 0);
        run_cycle(0, 1, 0);
        run_cycle(0, 0, 0);
        // Reset while waiting for the cache.
        reset = 1'b0; cache_flush_done = 1'b1;
        set_in(1, 1, 1, 1, 1, 1);
        @(negedge clk);
        chk_all_zero("reset_wait");
        @(posedge clk); #1;
        reset = 1'b1; q.delete(); pref = 1'b0;
        run_cycle(1, 0, 0);                                // done pulse after reset is no-op
        cache_flush_done = 1'b0;

        // Three outstanding (i, d, i), flush to draining, then reset mid-drain.
        for (int i = 0; i < 6; i++) begin
            set_in(0, 0, 1, 1, 1, 1);
            run_cycle(1, 0, 0);
        end
        set_in(1, 0, 1, 0, 1, 1); run_cycle(1, 0, 0);
        set_in(0, 1, 1, 0, 1, 1); run_cycle(1, 0, 0);
        set_in(1, 0, 1, 0, 1, 1); run_cycle(1, 0, 0);
        chk("pre_reset_depth", q.size(), 3);
        set_in(0, 0, 1, 0, 1, 1); flush = 1'b1;
        run_cycle(1, 0, 0);
        flush = 1'b0;
        reset = 1'b0;
        set_in(1, 1, 1, 1, 1, 1);
        @(negedge clk);
        chk_all_zero("reset_drain");
        @(posedge clk); #1;
        reset = 1'b1; q.delete(); pref = 1'b0;
        set_in(1, 1, 1, 1, 1, 1);                          // FIFO empty, imem wins the tie
        run_cycle(1, 0, 0);
        set_in(1, 1, 1, 1, 1, 1);
        run_cycle(1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
